// File: rtl/arb_fairness_monitor.sv
// Passive fairness and protocol monitor for the switch arbiter.
// Tracks per-port wait, sticky errors, worst wait and grant counts.
module arb_fairness_monitor #(
  parameter int NUM_PORTS    = 4,
  parameter int MAX_WAIT     = 20,
  parameter int WAIT_W       = 8,
  parameter int GCNT_W       = 16,
  parameter int ONEHOT_GRANT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        grant,
  input  logic                        clear,
  output logic [NUM_PORTS-1:0]        starve_err,
  output logic [NUM_PORTS-1:0]        no_req_err,
  output logic                        multi_err,
  output logic                        err_pulse,
  output logic [WAIT_W-1:0]           max_wait,
  output logic [NUM_PORTS*GCNT_W-1:0] grant_cnt
);

  localparam logic [WAIT_W-1:0] WSAT  = '1;
  localparam logic [WAIT_W-1:0] SWAIT = WAIT_W'(MAX_WAIT - 1);
  localparam logic [GCNT_W-1:0] GSAT  = '1;

  logic [WAIT_W-1:0]           wait_cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0]        hit;
  logic [NUM_PORTS-1:0]        miss;
  logic [NUM_PORTS-1:0]        starve_set;
  logic [NUM_PORTS-1:0]        noreq_set;
  logic                        multi_set;
  logic [WAIT_W-1:0]           cand;
  logic [NUM_PORTS-1:0]        starve_base;
  logic [NUM_PORTS-1:0]        noreq_base;
  logic                        multi_base;
  logic [WAIT_W-1:0]           max_base;
  logic [NUM_PORTS-1:0]        starve_nxt;
  logic [NUM_PORTS-1:0]        noreq_nxt;
  logic                        multi_nxt;
  logic [WAIT_W-1:0]           max_nxt;
  logic                        rise;
  logic [NUM_PORTS*GCNT_W-1:0] gcnt_nxt;

  // Error detection and worst-wait candidate from this cycle's sample
  always_comb begin
    hit        = req & grant;
    miss       = req & ~grant;
    noreq_set  = grant & ~req;
    starve_set = '0;
    cand       = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (miss[p] && wait_cnt[p] == SWAIT)
        starve_set[p] = 1'b1;
      if (hit[p] && wait_cnt[p] > cand)
        cand = wait_cnt[p];
    end
    multi_set = (ONEHOT_GRANT != 0) &&
                ((grant & (grant - NUM_PORTS'(1))) != '0);
  end

  // Clear first, then merge new events so a same-edge set wins
  always_comb begin
    starve_base = clear ? '0 : starve_err;
    noreq_base  = clear ? '0 : no_req_err;
    multi_base  = clear ? 1'b0 : multi_err;
    max_base    = clear ? '0 : max_wait;
    starve_nxt  = starve_base | starve_set;
    noreq_nxt   = noreq_base | noreq_set;
    multi_nxt   = multi_base | multi_set;
    max_nxt     = (cand > max_base) ? cand : max_base;
    rise        = |(starve_set & ~starve_base) |
                  |(noreq_set & ~noreq_base) |
                  (multi_set & ~multi_base);
  end

  // Saturating per-port grant counters
  always_comb begin
    gcnt_nxt = grant_cnt;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (hit[p] && grant_cnt[p*GCNT_W +: GCNT_W] != GSAT)
        gcnt_nxt[p*GCNT_W +: GCNT_W] =
          grant_cnt[p*GCNT_W +: GCNT_W] + GCNT_W'(1);
    end
  end

  // Per-port consecutive ungranted-request counters
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rst || !miss[p])
        wait_cnt[p] <= '0;
      else if (wait_cnt[p] != WSAT)
        wait_cnt[p] <= wait_cnt[p] + WAIT_W'(1);
    end
  end

  // Registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_err <= '0;
      no_req_err <= '0;
      multi_err  <= 1'b0;
      err_pulse  <= 1'b0;
      max_wait   <= '0;
      grant_cnt  <= '0;
    end else begin
      starve_err <= starve_nxt;
      no_req_err <= noreq_nxt;
      multi_err  <= multi_nxt;
      err_pulse  <= rise;
      max_wait   <= max_nxt;
      grant_cnt  <= gcnt_nxt;
    end
  end

endmodule
